// File: rtl/des_pkg.sv
// Shared types and constants for the DES mode-of-operation controller.
package des_pkg;

  localparam int DES_BLK_W = 64;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  // Conditional chaining XOR: returns a ^ b when en is set, a otherwise.
  function automatic logic [DES_BLK_W-1:0] cbc_xor(input logic en,
                                                   input logic [DES_BLK_W-1:0] a,
                                                   input logic [DES_BLK_W-1:0] b);
    logic [DES_BLK_W-1:0] r;
    if (en) begin
      r = a ^ b;
    end else begin
      r = a;
    end
    return r;
  endfunction

endpackage

// File: rtl/des_chain_unit.sv
// CBC chaining datapath: chain register plus the pre-core and post-core XORs.
module des_chain_unit
  import des_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_iv_i,
  input  logic [DES_BLK_W-1:0] iv_i,
  input  logic [DES_BLK_W-1:0] pre_data_i,
  input  logic                 pre_cbc_i,
  input  logic                 pre_dec_i,
  input  logic                 post_cbc_i,
  input  logic                 post_dec_i,
  input  logic [DES_BLK_W-1:0] blk_i,
  input  logic [DES_BLK_W-1:0] core_dout_i,
  input  logic                 upd_i,
  output logic [DES_BLK_W-1:0] pre_xor_o,
  output logic [DES_BLK_W-1:0] post_xor_o,
  output logic [DES_BLK_W-1:0] chain_o
);

  logic [DES_BLK_W-1:0] chain_q;
  logic [DES_BLK_W-1:0] chain_d;

  // Encrypt XORs before the core, decrypt XORs after it; ECB bypasses both.
  assign pre_xor_o  = cbc_xor(pre_cbc_i && !pre_dec_i, pre_data_i, chain_q);
  assign post_xor_o = cbc_xor(post_cbc_i && post_dec_i, core_dout_i, chain_q);
  assign chain_o    = chain_q;

  // Next chain value: IV load, or CBC feedback (ciphertext on both directions).
  always_comb begin
    chain_d = chain_q;
    if (load_iv_i) begin
      chain_d = iv_i;
    end else if (upd_i && post_cbc_i) begin
      if (post_dec_i) begin
        chain_d = blk_i;
      end else begin
        chain_d = core_dout_i;
      end
    end else begin
      chain_d = chain_q;
    end
  end

  // Chain register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

endmodule

// File: rtl/des_cbc_ctrl.sv
// ECB/CBC initiator sequencing an iterative DES core, one block in flight.
module des_cbc_ctrl
  import des_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_decrypt,
  input  logic        cfg_cbc,
  input  logic [63:0] key,
  input  logic [63:0] iv,
  input  logic        iv_load,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        busy,
  output logic        timeout_err,
  output logic [63:0] core_din,
  output logic [63:0] core_key,
  output logic        core_mode,
  output logic        core_start,
  input  logic [63:0] core_dout,
  input  logic        core_valid
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dec_q, dec_d;
  logic               cbc_q, cbc_d;
  logic [63:0]        blk_q, blk_d;
  logic [63:0]        core_din_q, core_din_d;
  logic [63:0]        core_key_q, core_key_d;
  logic               core_mode_q, core_mode_d;
  logic               core_start_q, core_start_d;
  logic               m_valid_q, m_valid_d;
  logic [63:0]        m_data_q, m_data_d;
  logic               tmo_q, tmo_d;
  logic               live_q;
  logic               iv_en_s;
  logic               upd_s;
  logic [63:0]        pre_xor_s;
  logic [63:0]        post_xor_s;
  logic [63:0]        chain_s;

  // live_q keeps s_ready low while reset is held and releases it afterwards.
  assign s_ready     = live_q && (state_q == ST_IDLE) && !iv_load;
  assign busy        = (state_q != ST_IDLE);
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign timeout_err = tmo_q;
  assign core_din    = core_din_q;
  assign core_key    = core_key_q;
  assign core_mode   = core_mode_q;
  assign core_start  = core_start_q;

  des_chain_unit u_chain (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_iv_i   (iv_en_s),
    .iv_i        (iv),
    .pre_data_i  (s_data),
    .pre_cbc_i   (cfg_cbc),
    .pre_dec_i   (cfg_decrypt),
    .post_cbc_i  (cbc_q),
    .post_dec_i  (dec_q),
    .blk_i       (blk_q),
    .core_dout_i (core_dout),
    .upd_i       (upd_s),
    .pre_xor_o   (pre_xor_s),
    .post_xor_o  (post_xor_s),
    .chain_o     (chain_s)
  );

  // Next-state and output logic; core_start_d is high only on entry to START.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dec_d        = dec_q;
    cbc_d        = cbc_q;
    blk_d        = blk_q;
    core_din_d   = core_din_q;
    core_key_d   = core_key_q;
    core_mode_d  = core_mode_q;
    core_start_d = 1'b0;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    tmo_d        = tmo_q;
    iv_en_s      = 1'b0;
    upd_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iv_load) begin
          iv_en_s = 1'b1;
        end else if (s_valid && live_q) begin
          dec_d       = cfg_decrypt;
          cbc_d       = cfg_cbc;
          blk_d       = s_data;
          core_din_d  = pre_xor_s;
          core_key_d  = key;
          core_mode_d = cfg_decrypt ? MODE_DEC : MODE_ENC;
          state_d     = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (!core_valid) begin
          core_start_d = 1'b1;
          state_d      = ST_START;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (core_valid) begin
          upd_s     = 1'b1;
          m_data_d  = post_xor_s;
          m_valid_d = 1'b1;
          state_d   = ST_OUT;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          m_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered core/result interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dec_q        <= 1'b0;
      cbc_q        <= 1'b0;
      blk_q        <= '0;
      core_din_q   <= '0;
      core_key_q   <= '0;
      core_mode_q  <= 1'b0;
      core_start_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      tmo_q        <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dec_q        <= dec_d;
      cbc_q        <= cbc_d;
      blk_q        <= blk_d;
      core_din_q   <= core_din_d;
      core_key_q   <= core_key_d;
      core_mode_q  <= core_mode_d;
      core_start_q <= core_start_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      tmo_q        <= tmo_d;
      live_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Self-checking bench for des_cbc_ctrl with a behavioural DES core responder.
module tb_des_cbc_ctrl;

  localparam int TMO = 64;
  localparam logic [63:0] K = 64'h133457799BBCDFF1;
  localparam logic [63:0] P = 64'h0123456789ABCDEF;
  localparam logic [63:0] C = 64'h85E813540F0AB405;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_decrypt = 1'b0, cfg_cbc = 1'b0, iv_load = 1'b0;
  logic        s_valid = 1'b0, m_ready = 1'b0;
  logic [63:0] key = '0, iv = '0, s_data = '0;
  logic        s_ready, m_valid, busy, timeout_err, core_mode, core_start;
  logic [63:0] m_data, core_din, core_key;
  logic [63:0] core_dout = '0;
  logic        core_valid = 1'b0;

  int n_chk = 0, n_pass = 0;
  int start_cnt = 0, dbl_start = 0, din_drift = 0;
  int core_lat = 2;
  bit core_mute = 1'b0;
  logic [63:0] st_din = '0;
  logic        st_mode = 1'b0;

  always #5 clk = ~clk;

  des_cbc_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_decrypt(cfg_decrypt), .cfg_cbc(cfg_cbc),
    .key(key), .iv(iv), .iv_load(iv_load), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .timeout_err(timeout_err), .core_din(core_din), .core_key(core_key),
    .core_mode(core_mode), .core_start(core_start), .core_dout(core_dout),
    .core_valid(core_valid)
  );

  // Stand-in cipher: the known DES vector in both directions, otherwise an invertible toy.
  function automatic logic [63:0] fake_des(input logic [63:0] k, input logic [63:0] x, input logic d);
    logic [63:0] t;
    if (!d && k == K && x == P) return C;
    if (d && k == K && x == C) return P;
    if (!d) begin
      t = x ^ k;
      return {t[50:0], t[63:51]};
    end
    t = {x[12:0], x[63:13]};
    return t ^ k;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Core responder: answers core_lat cycles after a start pulse, using its live inputs.
  initial begin
    int cd;
    bit prev;
    cd = -1;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cd = -1;
        core_valid = 1'b0;
        prev = 1'b0;
      end else begin
        core_valid = 1'b0;
        if (core_start) begin
          start_cnt++;
          if (prev) dbl_start++;
          st_din  = core_din;
          st_mode = core_mode;
          if (!core_mute) cd = core_lat;
        end else if (cd > 0) begin
          if (core_din !== st_din) din_drift++;
          cd--;
          if (cd == 0) begin
            core_valid = 1'b1;
            core_dout  = fake_des(core_key, core_din, core_mode);
            cd = -1;
          end
        end
        prev = core_start;
      end
    end
  end

  task automatic do_iv(input logic [63:0] v);
    iv = v;
    iv_load = 1'b1;
    s_valid = 1'b1;
    #1;
    chk("s_ready during iv_load", s_ready, 1'b0);
    tick();
    iv_load = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic send(input logic dec, input logic cbc, input logic [63:0] k, input logic [63:0] d);
    int n;
    cfg_decrypt = dec; cfg_cbc = cbc; key = k; s_data = d; s_valid = 1'b1;
    #1;
    n = 0;
    while (!s_ready && n < 50) begin
      tick(); #1; n++;
    end
    if (n == 50) chk("s_ready wait", s_ready, 1'b1);
    tick();
    s_valid = 1'b0;
    cfg_decrypt = ~dec; cfg_cbc = ~cbc; key = ~k; s_data = ~d;
  endtask

  task automatic run_block(input logic dec, input logic cbc, input logic [63:0] k,
                           input logic [63:0] d, input int bp, output logic [63:0] got);
    int n, errs, sc;
    logic [63:0] first;
    got = '0;
    send(dec, cbc, k, d);
    chk("core_mode from SETUP", core_mode, dec);
    n = 0;
    while (!m_valid && n < 300) begin
      tick(); n++;
    end
    if (!m_valid) begin
      chk("m_valid rise", 1'b0, 1'b1);
    end else begin
      first = m_data; sc = start_cnt; errs = 0;
      for (int i = 0; i < bp; i++) begin
        tick();
        if (m_data !== first || !m_valid || s_ready) errs++;
      end
      if (bp > 0) begin
        chk("backpressure hold", 64'(errs), 64'd0);
        chk("no extra core_start", 64'(start_cnt), 64'(sc));
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("m_valid drop after handshake", m_valid, 1'b0);
      chk("s_ready after handshake", s_ready, 1'b1);
      got = first;
    end
  endtask

  typedef struct {
    logic dec; logic cbc; logic ivld;
    logic [63:0] ivv, data, exp_din, exp_m, exp_chain;
  } vec_t;

  initial begin
    vec_t vt[3];
    logic [63:0] got, ch0, rc, e, x, k;
    logic dec, cbc;
    int n, bp;
    bit mv_seen;

    vt[0] = '{1'b0, 1'b0, 1'b0, 64'd0, P, P, C, 64'd0};
    vt[1] = '{1'b0, 1'b1, 1'b1, P, 64'd0, P, C, C};
    vt[2] = '{1'b1, 1'b1, 1'b1, P, C, C, 64'd0, C};

    // Reset values while rst_n is held.
    tick();
    chk("reset s_ready", s_ready, 1'b0);
    chk("reset m_valid", m_valid, 1'b0);
    chk("reset m_data", m_data, 64'd0);
    chk("reset core_din", core_din, 64'd0);
    chk("reset core_key", core_key, 64'd0);
    chk("reset core_mode/start", {core_mode, core_start, busy, timeout_err}, 4'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Directed vectors (ECB enc, CBC enc, CBC dec).
    for (int i = 0; i < 3; i++) begin
      if (vt[i].ivld) do_iv(vt[i].ivv);
      run_block(vt[i].dec, vt[i].cbc, K, vt[i].data, 0, got);
      chk($sformatf("vec%0d m_data", i), got, vt[i].exp_m);
      chk($sformatf("vec%0d core_din", i), st_din, vt[i].exp_din);
      chk($sformatf("vec%0d core_mode", i), st_mode, vt[i].dec);
      chk($sformatf("vec%0d chain", i), dut.u_chain.chain_q, vt[i].exp_chain);
    end

    // Backpressure for 10 cycles.
    run_block(1'b0, 1'b0, K, P, 10, got);
    chk("backpressure m_data", got, C);

    // Timeout with a silent core, measured from the cycle core_start falls.
    ch0 = dut.u_chain.chain_q;
    core_mute = 1'b1;
    send(1'b0, 1'b1, K, P);
    n = 0;
    while (!core_start && n < 10) begin tick(); n++; end
    chk("timeout core_start seen", core_start, 1'b1);
    tick();
    n = 0; mv_seen = 1'b0;
    while (!timeout_err && n < 200) begin
      tick(); n++;
      if (m_valid) mv_seen = 1'b1;
    end
    chk("timeout cycles", 64'(n), 64'(TMO));
    chk("timeout no m_valid", mv_seen, 1'b0);
    chk("timeout back to idle", busy, 1'b0);
    chk("timeout chain unchanged", dut.u_chain.chain_q, ch0);
    core_mute = 1'b0;
    run_block(1'b0, 1'b0, K, P, 0, got);
    chk("after timeout m_data", got, C);
    chk("timeout_err sticky", timeout_err, 1'b1);

    // Reset asserted in WAIT.
    core_lat = 30;
    send(1'b0, 1'b1, K, P);
    n = 0;
    while (!core_start && n < 10) begin tick(); n++; end
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy/start/mode/valid/tmo/ready", {busy, core_start, core_mode, m_valid, timeout_err, s_ready}, 6'd0);
    chk("rst core_din", core_din, 64'd0);
    chk("rst core_key", core_key, 64'd0);
    chk("rst chain", dut.u_chain.chain_q, 64'd0);
    tick();
    rst_n = 1'b1;
    core_lat = 2;
    tick(); tick();
    do_iv(64'hDEADBEEF_CAFEF00D);
    run_block(1'b0, 1'b0, K, P, 0, got);
    chk("post-reset ECB", got, C);

    // Randomised traffic against the reference model.
    rc = $urandom;
    rc = {rc[31:0], 32'($urandom)};
    do_iv(rc);
    for (int i = 0; i < 40; i++) begin
      dec = 1'($urandom_range(0, 1));
      cbc = 1'($urandom_range(0, 1));
      k = {32'($urandom), 32'($urandom)};
      x = {32'($urandom), 32'($urandom)};
      bp = $urandom_range(0, 2);
      core_lat = $urandom_range(1, 6);
      if ($urandom_range(0, 4) == 0) begin
        e = {32'($urandom), 32'($urandom)};
        do_iv(e);
        rc = e;
      end
      if (!cbc) e = fake_des(k, x, dec);
      else if (!dec) begin e = fake_des(k, x ^ rc, 1'b0); rc = e; end
      else begin e = fake_des(k, x, 1'b1) ^ rc; rc = x; end
      run_block(dec, cbc, k, x, bp, got);
      chk($sformatf("rand%0d m_data", i), got, e);
      chk($sformatf("rand%0d chain", i), dut.u_chain.chain_q, rc);
    end

    chk("core_start single cycle", 64'(dbl_start), 64'd0);
    chk("core_din stable in WAIT", 64'(din_drift), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/des_cbc_ctrl.md
Name: des_cbc_ctrl

Overview:
Mode-of-operation initiator that drives the iterative DES core. It accepts 64-bit blocks over a valid/ready stream and applies ECB or CBC chaining (XOR with IV or previous ciphertext). It sequences the core's start/mode/data inputs, waits for the core's completion strobe, and returns each result on an output valid/ready stream. It sits between the host datapath and the DES core, which acts as the responder.

Parameters:
TIMEOUT_CYC, 64, maximum WAIT cycles before the block is dropped and timeout_err is set.
CNT_W, 7, width of the WAIT counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled at block accept
cfg_cbc  in  1  1 = CBC, 0 = ECB; sampled at block accept
key  in  64  DES key; sampled at block accept
iv  in  64  initialisation vector
iv_load  in  1  loads iv into the chain register; acted on in IDLE only
s_valid  in  1  input block valid
s_ready  out  1  input block ready
s_data  in  64  input block (plaintext or ciphertext)
m_valid  out  1  result valid
m_ready  in  1  result ready
m_data  out  64  result block
busy  out  1  high whenever state != IDLE
timeout_err  out  1  sticky; cleared only by reset
core_din  out  64  DES core data input, registered
core_key  out  64  DES core key, registered
core_mode  out  1  DES core mode (0 = encrypt, 1 = decrypt), registered
core_start  out  1  DES core start, registered
core_dout  in  64  DES core result
core_valid  in  1  DES core completion strobe

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state = IDLE; s_ready = 0 during reset; m_valid = 0; m_data = 0; core_din = 0; core_key = 0; core_mode = 0; core_start = 0; chain = 0; timeout_err = 0; counter = 0.
- States: IDLE, SETUP, START, WAIT, OUT.
- IDLE:
  - s_ready = !iv_load.
  - If iv_load is high: chain <= iv; no block is accepted that cycle.
  - On s_valid && s_ready (accept): latch cfg_decrypt, cfg_cbc, key, and s_data into blk. Then core_din <= (cbc && !dec) ? s_data ^ chain : s_data; core_mode <= dec; core_key <= key. Go to SETUP.
- SETUP:
  - core_start = 0. Holds until core_valid == 0, then goes to START.
  - This guarantees the mode is stable for at least one cycle before the start edge and that the previous completion strobe has cleared.
- START: core_start = 1 for exactly one cycle; counter cleared; go to WAIT.
- WAIT:
  - core_start = 0; counter increments each cycle.
  - On core_valid: compute m_data <= (cbc && dec) ? core_dout ^ chain : core_dout. Chain update in CBC: encrypt gives chain <= core_dout; decrypt gives chain <= blk. ECB leaves chain unchanged. Assert m_valid; go to OUT.
  - If counter == TIMEOUT_CYC - 1 with no core_valid: timeout_err <= 1; block is dropped; chain is unchanged; go to IDLE.
  - core_valid takes priority over timeout in the same cycle.
- OUT: m_valid held with m_data stable until m_ready; on the handshake, m_valid <= 0 and go to IDLE.
- core_din, core_key, and core_mode are held constant from accept until the block leaves WAIT. The core samples data combinationally throughout the rounds.
- iv_load outside IDLE is ignored.
- core_valid outside WAIT is ignored.
- Latency: accept at cycle T; core_start high at T+2 (if core_valid is already low); m_valid rises the cycle after core_valid is first seen in WAIT.
- Throughput: one block in flight; s_ready = 0 in every state other than IDLE.

Decomposition:
- Package des_pkg holds: the state enum (IDLE/SETUP/START/WAIT/OUT), the DES_BLK_W = 64 constant, and the mode encodings MODE_ENC = 0 and MODE_DEC = 1.
- Sub-module des_chain_unit (combinational plus chain register) holds the pre-XOR, post-XOR, chain register, and iv load.
- The FSM and counter stay in des_cbc_ctrl.

Test Plan:
- ECB encrypt: key 133457799BBCDFF1, s_data 0123456789ABCDEF -> m_data 85E813540F0AB405; core_start high for exactly 1 cycle; core_din stable until core_valid.
- CBC encrypt: iv_load with iv 0123456789ABCDEF, s_data 0000000000000000, same key -> core_din 0123456789ABCDEF, m_data 85E813540F0AB405, chain = 85E813540F0AB405.
- CBC decrypt: iv_load with iv 0123456789ABCDEF, s_data 85E813540F0AB405, cfg_decrypt = 1 -> core_mode = 1 from SETUP onward; m_data 0000000000000000; chain = 85E813540F0AB405.
- Backpressure: m_ready held low for 10 cycles after m_valid -> m_data unchanged, s_ready = 0, no second core_start; releasing m_ready returns to IDLE and s_ready = 1 on the next cycle.
- Timeout: core model never asserts core_valid -> timeout_err = 1 exactly TIMEOUT_CYC cycles after START; m_valid never rises; chain unchanged; the next block then completes normally.
- Reset in WAIT: drop rst_n mid-operation -> all outputs return to their reset values immediately; after release, iv_load plus the ECB vector above produces the correct result.
